// File: rtl/count_window_ctrl.sv
// Measurement-window controller for an external CNT_W-bit event counter.
// Synchronises and edge-detects an asynchronous event line. A start command clears
// the counter, then gates event edges into count_en for win_len clock cycles. At the
// end of the window the counter value and a wrap flag are captured into a result
// register and a one-cycle done pulse is raised.
module count_window_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             event_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             overflow_in,
  output logic             count_clr,
  output logic             count_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             result_sat
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StClear  = 2'd1,
    StArm    = 2'd2,
    StSettle = 2'd3
  } state_e;

  localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);

  // Event synchroniser and edge detector
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   ev_sync;
  logic                   ev_rise;

  // Control state
  state_e           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             sat_q, sat_d;

  assign ev_sync = sync_q[SYNC_STAGES-1];
  // One cycle per low->high transition of the synchronised line.
  assign ev_rise = ev_sync & ~prev_q;

  // Shift the raw event line through the synchroniser chain; keep the previous output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      prev_q <= ev_sync;
    end
  end

  // State, window timer, wrap flag and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  // Next-state logic and counter control strobes; abort kills the strobes in the same cycle.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    result_d  = result_q;
    sat_d     = sat_q;
    count_clr = 1'b0;
    count_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StClear;
          // A zero length still gives one counting cycle.
          timer_d = (win_len == '0) ? WinOne : win_len;
        end
      end

      StClear: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          count_clr = 1'b1;
          wrap_d    = 1'b0;
          state_d   = StArm;
        end
      end

      StArm: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          count_en = ev_rise;
          // Counter sits at all-ones and is about to roll over to zero.
          if (ev_rise && overflow_in) begin
            wrap_d = 1'b1;
          end
          // Timer counts down to 1 and never passes through 0, so max length cannot wrap.
          if (timer_q == WinOne) begin
            state_d = StSettle;
          end else begin
            timer_d = timer_q - WinOne;
          end
        end
      end

      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          // count_in already reflects the final ARM-cycle increment here.
          result_d = count_in;
          sat_d    = wrap_q;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign result     = result_q;
  assign result_sat = sat_q;

  // Clear and enable are never requested together.
  property p_clr_en_exclusive;
    @(posedge clk) disable iff (rst) !(count_clr && count_en);
  endproperty
  assert property (p_clr_en_exclusive);

  // The done pulse only appears once back in IDLE.
  property p_done_idle;
    @(posedge clk) disable iff (rst) done |-> !busy;
  endproperty
  assert property (p_done_idle);

  // The window timer is never zero while counting.
  property p_timer_nonzero;
    @(posedge clk) disable iff (rst) (state_q == StArm) |-> (timer_q != '0);
  endproperty
  assert property (p_timer_nonzero);

endmodule

// File: tb/tb_count_window_ctrl.sv
// Self-checking bench for count_window_ctrl. A behavioural 8-bit counter closes the loop;
// expected window results come from counting event rising edges that land in the window.
module tb_count_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] win_len;
  logic        event_in;
  logic [7:0]  count_in;
  logic        overflow_in;
  logic        count_clr;
  logic        count_en;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        result_sat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Value driven on event_in during each cycle (cycle n = period after posedge n).
  logic in_hist [0:32767];

  logic [7:0] exp_result;
  logic       exp_sat;
  logic [7:0] cnt_q;

  count_window_ctrl #(
    .CNT_W(8),
    .WIN_W(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .win_len    (win_len),
    .event_in   (event_in),
    .count_in   (count_in),
    .overflow_in(overflow_in),
    .count_clr  (count_clr),
    .count_en   (count_en),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .result_sat (result_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream event counter
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else if (count_clr) cnt_q <= 8'd0;
    else if (count_en) cnt_q <= cnt_q + 8'd1;
  end
  assign count_in    = cnt_q;
  assign overflow_in = (cnt_q == 8'hFF);

  // Two-flop synchroniser: an edge driven in cycle c-2 is seen as a rise in cycle c.
  function automatic logic rise(input int c);
    return in_hist[c-2] & ~in_hist[c-3];
  endfunction

  // per == 0: random with density dens%; otherwise cnt pulses of width wid every per cycles.
  function automatic logic ev_at(input int i, input int per, input int wid, input int cnt,
                                 input int dens);
    if (per == 0) return ($urandom_range(99) < dens);
    return (i < per * cnt) && ((i % per) < wid);
  endfunction

  task automatic drive_ev(input logic v);
    event_in    = v;
    in_hist[cyc] = v;
  endtask

  task automatic idle(input int n, input int dens);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      drive_ev($urandom_range(99) < dens);
      #1;
      total++;
      if (busy !== 1'b0 || count_en !== 1'b0 || count_clr !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle cyc=%0d busy=%b en=%b clr=%b done=%b required all 0",
                 cyc, busy, count_en, count_clr, done);
      end
      total++;
      if (result !== exp_result || result_sat !== exp_sat) begin
        bad++;
        $display("FAIL idle_result cyc=%0d got=%0d/%b required=%0d/%b",
                 cyc, result, result_sat, exp_result, exp_sat);
      end
    end
  endtask

  // One window: loop index i maps to cycle k-1+i (i=0 is the cycle start is driven).
  // abort_i: index at which abort is asserted (-1 none). busy_start: pulse start while busy.
  task automatic run_window(input int wl, input int per, input int wid, input int cnt,
                            input int dens, input int abort_i, input bit busy_start,
                            input string name);
    int n;
    int k;
    int c;
    int ph;
    int edges;
    int abort_c;
    logic e_en;
    logic e_clr;
    logic e_done;
    n       = (wl == 0) ? 1 : wl;
    edges   = 0;
    abort_c = -1;
    @(negedge clk);
    start   = 1'b1;
    abort   = 1'b0;
    win_len = 16'(wl);
    drive_ev(ev_at(0, per, wid, cnt, dens));
    k = cyc + 1;
    #1;
    total++;
    if (busy !== 1'b0 || count_clr !== 1'b0) begin
      bad++;
      $display("FAIL %s_pre busy=%b clr=%b required 0/0", name, busy, count_clr);
    end
    for (int i = 1; i <= n + 4; i++) begin
      @(negedge clk);
      c = cyc;
      if (abort_c >= 0 && c > abort_c) ph = 0;
      else if (c == k) ph = 1;
      else if (c >= k + 1 && c <= k + n) ph = 2;
      else if (c == k + n + 1) ph = 3;
      else ph = 0;
      start   = (busy_start && ph != 0) ? 1'($urandom_range(1)) : 1'b0;
      abort   = (i == abort_i && ph != 0);
      win_len = 16'($urandom);
      drive_ev(ev_at(i, per, wid, cnt, dens));
      #1;
      e_clr  = (ph == 1) && !abort;
      e_en   = (ph == 2) && !abort && rise(c);
      e_done = (c == k + n + 2) && (abort_c < 0);
      if (e_en) edges++;
      if (abort) abort_c = c;
      if (e_done) begin
        exp_result = 8'(edges % 256);
        exp_sat    = (edges >= 256);
      end
      total++;
      if (busy !== (ph != 0)) begin
        bad++;
        $display("FAIL %s_busy cyc=%0d got=%b required=%b", name, c, busy, ph != 0);
      end
      total++;
      if (count_clr !== e_clr) begin
        bad++;
        $display("FAIL %s_clr cyc=%0d got=%b required=%b", name, c, count_clr, e_clr);
      end
      total++;
      if (count_en !== e_en) begin
        bad++;
        $display("FAIL %s_en cyc=%0d got=%b required=%b", name, c, count_en, e_en);
      end
      total++;
      if (done !== e_done) begin
        bad++;
        $display("FAIL %s_done cyc=%0d got=%b required=%b", name, c, done, e_done);
      end
      total++;
      if (result !== exp_result || result_sat !== exp_sat) begin
        bad++;
        $display("FAIL %s_result cyc=%0d got=%0d/%b required=%0d/%b",
                 name, c, result, result_sat, exp_result, exp_sat);
      end
      if (abort_c >= 0 && c > abort_c + 2) break;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    win_len  = 16'd0;
    event_in = 1'b0;
    exp_result = 8'd0;
    exp_sat    = 1'b0;
    #7;
    total++;
    if (count_clr !== 1'b0 || count_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        result !== 8'd0 || result_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset clr=%b en=%b busy=%b done=%b result=%0d sat=%b required all 0",
               count_clr, count_en, busy, done, result, result_sat);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(5, 0);
  endtask

  task automatic test_basic();
    idle(4, 0);
    run_window(10, 2, 1, 4, 0, -1, 1'b0, "basic");
    total++;
    if (exp_result !== 8'd4 || result !== 8'd4 || result_sat !== 1'b0) begin
      bad++;
      $display("FAIL basic_final got=%0d/%b required=4/0", result, result_sat);
    end
  endtask

  task automatic test_wrap();
    idle(4, 0);
    run_window(520, 2, 1, 257, 0, -1, 1'b0, "wrap");
    total++;
    if (result !== 8'd1 || result_sat !== 1'b1) begin
      bad++;
      $display("FAIL wrap_final got=%0d/%b required=1/1", result, result_sat);
    end
  endtask

  task automatic test_zero_len();
    idle(4, 0);
    run_window(0, 4, 2, 1, 0, -1, 1'b0, "zero");
    total++;
    if (result !== 8'd1 || result_sat !== 1'b0) begin
      bad++;
      $display("FAIL zero_final got=%0d/%b required=1/0", result, result_sat);
    end
  endtask

  task automatic test_abort();
    logic [7:0] prior;
    idle(4, 0);
    prior = exp_result;
    run_window(20, 2, 1, 2, 0, 6, 1'b0, "abort");
    total++;
    if (result !== prior) begin
      bad++;
      $display("FAIL abort_keep got=%0d required=%0d", result, prior);
    end
    idle(3, 0);
  endtask

  task automatic test_start_ignored();
    idle(4, 0);
    run_window(12, 0, 0, 0, 40, -1, 1'b1, "busystart");
    idle(4, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      start = (j == 0);
      abort = (j == 0);
      drive_ev(1'b0);
      #1;
      total++;
      if (busy !== 1'b0 || count_clr !== 1'b0) begin
        bad++;
        $display("FAIL start_abort cyc=%0d busy=%b clr=%b required 0/0", cyc, busy, count_clr);
      end
    end
  endtask

  task automatic test_rst_mid();
    idle(4, 0);
    @(negedge clk);
    start   = 1'b1;
    win_len = 16'd50;
    drive_ev(1'b0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      drive_ev(1'b0);
    end
    @(negedge clk);
    drive_ev(1'b1);
    #3;
    rst = 1'b1;
    #1;
    exp_result = 8'd0;
    exp_sat    = 1'b0;
    total++;
    if (count_clr !== 1'b0 || count_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        result !== 8'd0 || result_sat !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid clr=%b en=%b busy=%b done=%b result=%0d sat=%b required all 0",
               count_clr, count_en, busy, done, result, result_sat);
    end
    @(negedge clk);
    drive_ev(1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive_ev(1'b1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      drive_ev(1'b1);
      #1;
      total++;
      if (busy !== 1'b0 || count_en !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL rst_after cyc=%0d busy=%b en=%b done=%b required 0/0/0",
                 cyc, busy, count_en, done);
      end
    end
    idle(4, 0);
  endtask

  task automatic test_random();
    int wl;
    int ab;
    for (int t = 0; t < 10; t++) begin
      idle($urandom_range(3, 6), 30);
      wl = $urandom_range(0, 30);
      ab = ($urandom_range(2) == 0) ? $urandom_range(1, ((wl == 0) ? 1 : wl) + 2) : -1;
      run_window(wl, 0, 0, 0, $urandom_range(10, 60), ab, 1'($urandom_range(1)), "rand");
    end
  endtask

  initial begin
    for (int j = 0; j < 32768; j++) in_hist[j] = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_abort();
    test_start_ignored();
    test_random();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
